// File: rtl/i2d_core_defines.sv
// Shared i2d core definitions: opcode encoding, EX sequencer states and
// opcode classification helpers used by both decode and execute.
package i2d_core_defines;

    typedef enum logic [3:0] {
        OpAdd = 4'd0,
        OpSub = 4'd1,
        OpAnd = 4'd2,
        OpOr  = 4'd3,
        OpXor = 4'd4,
        OpSll = 4'd5,
        OpSrl = 4'd6,
        OpMul = 4'd7,
        OpDiv = 4'd8,
        OpLd  = 4'd9,
        OpSt  = 4'd10,
        OpBeq = 4'd11,
        OpJal = 4'd12,
        OpNop = 4'd13
    } opcode_t;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StMem  = 2'd2
    } ex_seq_state_t;

    function automatic logic is_muldiv(opcode_t op);
        return (op == OpMul) || (op == OpDiv);
    endfunction

    function automatic logic is_mem(opcode_t op);
        return (op == OpLd) || (op == OpSt);
    endfunction

    function automatic int unsigned max_u(int unsigned a, int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/core_ex_cnt.sv
// Loadable down-counter shared by the EX sequencer for ALU cycle counts and
// memory timeouts. Load has priority over decrement; decrement saturates at 0.
module core_ex_cnt #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/core_ex_seq.sv
// Execute-stage sequencer: holds EX for multi-cycle MUL/DIV and memory
// accesses, and qualifies write-back so it commits once, never when aborted.
module core_ex_seq
    import i2d_core_defines::*;
#(
    parameter int unsigned MUL_CYCLES  = 3,
    parameter int unsigned DIV_CYCLES  = 16,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic    i_clk,
    input  logic    i_rst,
    input  opcode_t i_ex_opcode,
    input  logic    i_ex_new,
    input  logic    i_flush,
    output logic    o_alu_start,
    output logic    o_mau_req,
    output logic    o_mau_we,
    input  logic    i_mau_ack,
    output logic    o_ex_halt,
    output logic    o_wb_en,
    output logic    o_bus_err
);

    localparam int unsigned CntMax = max_u(max_u(DIV_CYCLES, MEM_TIMEOUT), MUL_CYCLES);
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    // Cycle 0 is spent in IDLE, so the EXEC count starts at N-2.
    localparam logic [CntW-1:0] MulLoad = CntW'((MUL_CYCLES >= 2) ? MUL_CYCLES - 2 : 0);
    localparam logic [CntW-1:0] DivLoad = CntW'((DIV_CYCLES >= 2) ? DIV_CYCLES - 2 : 0);
    localparam logic [CntW-1:0] MemLoad = CntW'((MEM_TIMEOUT >= 1) ? MEM_TIMEOUT - 1 : 0);

    ex_seq_state_t   r_state, w_state_nxt;
    logic            r_flush_pend, w_flush_pend_nxt;
    logic            r_st, w_st_nxt;

    logic            w_cnt_load;
    logic [CntW-1:0] w_cnt_load_val;
    logic            w_cnt_dec;
    logic            w_cnt_zero;

    logic            w_alu_start;
    logic            w_mau_req;
    logic            w_mau_we;
    logic            w_ex_halt;
    logic            w_wb_en;
    logic            w_bus_err;
    logic            w_is_mul;
    logic            w_one_cycle;
    logic            w_pend;

    core_ex_cnt #(
        .WIDTH (CntW)
    ) u_cnt (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_load_val),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    assign w_is_mul    = (i_ex_opcode == OpMul);
    assign w_one_cycle = w_is_mul ? (MUL_CYCLES <= 1) : (DIV_CYCLES <= 1);
    assign w_pend      = r_flush_pend | i_flush;

    always_comb begin
        w_state_nxt      = r_state;
        w_flush_pend_nxt = r_flush_pend;
        w_st_nxt         = r_st;
        w_cnt_load       = 1'b0;
        w_cnt_load_val   = '0;
        w_cnt_dec        = 1'b0;
        w_alu_start      = 1'b0;
        w_mau_req        = 1'b0;
        w_mau_we         = 1'b0;
        w_ex_halt        = 1'b0;
        w_wb_en          = 1'b0;
        w_bus_err        = 1'b0;

        case (r_state)
            StIdle: begin
                w_flush_pend_nxt = 1'b0;
                if (i_ex_new) begin
                    if (is_mem(i_ex_opcode)) begin
                        // A memory request is never torn; a flush only marks it.
                        w_mau_req = 1'b1;
                        w_mau_we  = (i_ex_opcode == OpSt);
                        if (i_mau_ack) begin
                            w_wb_en = (i_ex_opcode == OpLd) && !i_flush;
                        end else begin
                            w_ex_halt        = 1'b1;
                            w_cnt_load       = 1'b1;
                            w_cnt_load_val   = MemLoad;
                            w_st_nxt         = (i_ex_opcode == OpSt);
                            w_flush_pend_nxt = i_flush;
                            w_state_nxt      = StMem;
                        end
                    end else if (i_flush) begin
                        w_state_nxt = StIdle;
                    end else if (is_muldiv(i_ex_opcode)) begin
                        w_alu_start = 1'b1;
                        if (w_one_cycle) begin
                            w_wb_en = 1'b1;
                        end else begin
                            w_ex_halt      = 1'b1;
                            w_cnt_load     = 1'b1;
                            w_cnt_load_val = w_is_mul ? MulLoad : DivLoad;
                            w_state_nxt    = StExec;
                        end
                    end else begin
                        w_wb_en = 1'b1;
                    end
                end
            end

            StExec: begin
                if (i_flush) begin
                    w_state_nxt = StIdle;
                end else if (!w_cnt_zero) begin
                    w_ex_halt = 1'b1;
                    w_cnt_dec = 1'b1;
                end else begin
                    w_wb_en     = 1'b1;
                    w_state_nxt = StIdle;
                end
            end

            StMem: begin
                w_mau_req = 1'b1;
                w_mau_we  = r_st;
                if (i_mau_ack) begin
                    w_wb_en          = !r_st && !w_pend;
                    w_flush_pend_nxt = 1'b0;
                    w_state_nxt      = StIdle;
                end else if (w_cnt_zero) begin
                    w_bus_err        = 1'b1;
                    w_flush_pend_nxt = 1'b0;
                    w_state_nxt      = StIdle;
                end else begin
                    w_ex_halt        = 1'b1;
                    w_cnt_dec        = 1'b1;
                    w_flush_pend_nxt = w_pend;
                end
            end

            default: begin
                w_state_nxt      = StIdle;
                w_flush_pend_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_flush_pend <= 1'b0;
            r_st         <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_flush_pend <= w_flush_pend_nxt;
            r_st         <= w_st_nxt;
        end
    end

    // Mealy outputs would otherwise follow ex_new while reset is held.
    assign o_alu_start = w_alu_start & ~i_rst;
    assign o_mau_req   = w_mau_req & ~i_rst;
    assign o_mau_we    = w_mau_we & ~i_rst;
    assign o_ex_halt   = w_ex_halt & ~i_rst;
    assign o_wb_en     = w_wb_en & ~i_rst;
    assign o_bus_err   = w_bus_err & ~i_rst;

endmodule

// File: tb/tb_core_ex_seq.sv
// Directed bench for core_ex_seq: single-cycle vector table from IDLE plus
// hand-written multi-cycle sequences (MUL/DIV, LD/ST, timeout, flush, reset).
module tb_core_ex_seq;
    import i2d_core_defines::*;

    logic    clk;
    logic    rst;
    opcode_t ex_opcode;
    logic    ex_new;
    logic    flush;
    logic    mau_ack;
    logic    alu_start, mau_req, mau_we, ex_halt, wb_en, bus_err;
    logic [5:0] outs;

    int total;
    int bad;

    // {alu_start, mau_req, mau_we, ex_halt, wb_en, bus_err}
    assign outs = {alu_start, mau_req, mau_we, ex_halt, wb_en, bus_err};

    core_ex_seq #(
        .MUL_CYCLES  (3),
        .DIV_CYCLES  (16),
        .MEM_TIMEOUT (8)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_ex_opcode (ex_opcode),
        .i_ex_new    (ex_new),
        .i_flush     (flush),
        .o_alu_start (alu_start),
        .o_mau_req   (mau_req),
        .o_mau_we    (mau_we),
        .i_mau_ack   (mau_ack),
        .o_ex_halt   (ex_halt),
        .o_wb_en     (wb_en),
        .o_bus_err   (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        opcode_t    op;
        logic       nw;
        logic       fl;
        logic       ack;
        logic [5:0] exp;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [5:0] exp);
        total++;
        if (outs !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b (alu,req,we,halt,wb,err) t=%0t",
                     name, outs, exp, $time);
        end
    endtask

    // Drive one cycle's inputs just after a rising edge, check mid-cycle,
    // then advance to just after the next rising edge.
    task automatic cyc(input opcode_t op, input logic nw, input logic fl, input logic ack,
                       input logic [5:0] exp, input string name);
        ex_opcode = op;
        ex_new    = nw;
        flush     = fl;
        mau_ack   = ack;
        #2;
        chk(name, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        ex_opcode = OpAdd;
        ex_new    = 1'b1;
        flush     = 1'b0;
        mau_ack   = 1'b0;

        // Outputs stay 0 under reset even with a live ex_new.
        #2;
        chk("reset_outputs", 6'b000000);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        ex_new = 1'b0;
        @(posedge clk);
        #1;

        tbl[0] = '{OpAdd, 1'b1, 1'b0, 1'b0, 6'b000010};
        tbl[1] = '{OpAdd, 1'b1, 1'b1, 1'b0, 6'b000000};
        tbl[2] = '{OpSub, 1'b0, 1'b0, 1'b0, 6'b000000};
        tbl[3] = '{opcode_t'(4'hF), 1'b1, 1'b0, 1'b0, 6'b000010};
        tbl[4] = '{OpSt,  1'b1, 1'b0, 1'b1, 6'b011000};
        tbl[5] = '{OpLd,  1'b1, 1'b0, 1'b1, 6'b010010};
        tbl[6] = '{OpLd,  1'b1, 1'b1, 1'b1, 6'b010000};
        tbl[7] = '{OpMul, 1'b1, 1'b1, 1'b0, 6'b000000};
        tbl[8] = '{OpAdd, 1'b0, 1'b0, 1'b1, 6'b000000};
        tbl[9] = '{OpXor, 1'b1, 1'b0, 1'b1, 6'b000010};
        for (int i = 0; i < 10; i++) begin
            cyc(tbl[i].op, tbl[i].nw, tbl[i].fl, tbl[i].ack, tbl[i].exp,
                $sformatf("vec%0d", i));
        end

        // MUL, 3 cycles, then back-to-back ADD.
        cyc(OpMul, 1'b1, 1'b0, 1'b0, 6'b100100, "mul_c0");
        cyc(OpMul, 1'b0, 1'b0, 1'b0, 6'b000100, "mul_c1");
        cyc(OpMul, 1'b0, 1'b0, 1'b0, 6'b000010, "mul_c2");
        cyc(OpAdd, 1'b1, 1'b0, 1'b0, 6'b000010, "mul_b2b_add");

        // DIV, 16 cycles: 15 halt cycles then write-back.
        cyc(OpDiv, 1'b1, 1'b0, 1'b0, 6'b100100, "div_c0");
        for (int c = 1; c < 15; c++) begin
            cyc(OpDiv, 1'b0, 1'b0, 1'b0, 6'b000100, $sformatf("div_c%0d", c));
        end
        cyc(OpDiv, 1'b0, 1'b0, 1'b0, 6'b000010, "div_c15");
        cyc(OpNop, 1'b0, 1'b0, 1'b0, 6'b000000, "div_after");

        // LD acked 4 cycles after the request.
        cyc(OpLd, 1'b1, 1'b0, 1'b0, 6'b010100, "ld_c0");
        for (int c = 1; c < 4; c++) begin
            cyc(OpLd, 1'b0, 1'b0, 1'b0, 6'b010100, $sformatf("ld_c%0d", c));
        end
        cyc(OpLd, 1'b0, 1'b0, 1'b1, 6'b010010, "ld_ack");
        cyc(OpLd, 1'b0, 1'b0, 1'b0, 6'b000000, "ld_req_drop");

        // ST acked one cycle later: wb_en stays low.
        cyc(OpSt, 1'b1, 1'b0, 1'b0, 6'b011100, "st_c0");
        cyc(OpSt, 1'b0, 1'b0, 1'b1, 6'b011000, "st_ack");

        // LD timeout: bus_err in cycle 8, then ADD accepted.
        cyc(OpLd, 1'b1, 1'b0, 1'b0, 6'b010100, "to_c0");
        for (int c = 1; c < 8; c++) begin
            cyc(OpLd, 1'b0, 1'b0, 1'b0, 6'b010100, $sformatf("to_c%0d", c));
        end
        cyc(OpLd, 1'b0, 1'b0, 1'b0, 6'b010001, "to_bus_err");
        cyc(OpAdd, 1'b1, 1'b0, 1'b0, 6'b000010, "to_next_add");

        // Flush in EXEC cycle 1 of DIV.
        cyc(OpDiv, 1'b1, 1'b0, 1'b0, 6'b100100, "fdiv_c0");
        cyc(OpDiv, 1'b0, 1'b1, 1'b0, 6'b000000, "fdiv_flush");
        cyc(OpDiv, 1'b0, 1'b0, 1'b0, 6'b000000, "fdiv_idle");
        cyc(OpAdd, 1'b1, 1'b0, 1'b0, 6'b000010, "fdiv_add");

        // Flush during LD wait: request held, wb_en suppressed at ack.
        cyc(OpLd, 1'b1, 1'b0, 1'b0, 6'b010100, "fld_c0");
        cyc(OpLd, 1'b0, 1'b1, 1'b0, 6'b010100, "fld_flush");
        cyc(OpLd, 1'b0, 1'b0, 1'b0, 6'b010100, "fld_wait");
        cyc(OpLd, 1'b0, 1'b0, 1'b1, 6'b010000, "fld_ack");
        cyc(OpLd, 1'b0, 1'b0, 1'b0, 6'b000000, "fld_idle");

        // Flush on the LD ex_new cycle itself.
        cyc(OpLd, 1'b1, 1'b1, 1'b0, 6'b010100, "fnew_c0");
        cyc(OpLd, 1'b0, 1'b0, 1'b1, 6'b010000, "fnew_ack");

        // ex_new while in EXEC is ignored.
        cyc(OpMul, 1'b1, 1'b0, 1'b0, 6'b100100, "ign_c0");
        cyc(OpMul, 1'b1, 1'b0, 1'b0, 6'b000100, "ign_c1");
        cyc(OpMul, 1'b1, 1'b0, 1'b0, 6'b000010, "ign_c2");

        // Asynchronous reset during MEM.
        cyc(OpLd, 1'b1, 1'b0, 1'b0, 6'b010100, "rmem_c0");
        ex_new = 1'b0;
        #2;
        chk("rmem_wait", 6'b010100);
        rst = 1'b1;
        #1;
        chk("rmem_async", 6'b000000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(OpAdd, 1'b1, 1'b0, 1'b0, 6'b000010, "rmem_add");
        cyc(OpAdd, 1'b0, 1'b0, 1'b0, 6'b000000, "rmem_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
